cond_logic: RTL

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic_pkg.sv | 47 ++++
 rtl/cond_logic_cond_check.sv | 40 ++++
 rtl/cond_logic.sv | 55 +++++
 3 files changed

// File: rtl/cond_logic_pkg.sv
// Shared ARM decode constants: condition codes, flag bit positions,
// ALUControl and FlagW encodings.
package cond_logic_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] FLAGS_RESET = 4'b0000;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_e;

    // FlagW: bit 1 guards the N,Z group, bit 0 guards the C,V group.
    localparam int FLAGW_NZ_BIT = 1;
    localparam int FLAGW_CV_BIT = 0;

    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_CV   = 2'b01;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Purely combinational condition evaluation of Cond against the
// architectural flags.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v, ge;

    assign n  = Flags[FLAG_N];
    assign z  = Flags[FLAG_Z];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~z & ge;
            COND_LE: CondEx = z | ~ge;
            default: CondEx = 1'b1;  // AL and the 1111 encoding both execute
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: architectural NZCV register plus gating of
// PC, register and memory write requests by the condition outcome.
module cond_logic
    import cond_logic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       En,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       CondEx,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags
);

    logic       cond_ex;
    logic       go;
    logic [1:0] flag_we;

    // Evaluated against the registered flags, so an instruction never sees
    // its own flag update.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (cond_ex)
    );

    assign CondEx = cond_ex;
    assign go     = En & cond_ex & reset;

    assign PCSrc    = PCS  & go;
    assign RegWrite = RegW & go;
    assign MemWrite = MemW & go;

    // An unknown FlagW is masked to 0 whenever the instruction does not go.
    assign flag_we = FlagW & {2{go}};

    always_ff @(posedge clk) begin
        if (!reset) begin
            Flags <= FLAGS_RESET;
        end else begin
            if (flag_we[FLAGW_NZ_BIT])
                Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (flag_we[FLAGW_CV_BIT])
                Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

endmodule
